debounce_sync: RTL

- Conditions a raw asynchronous input (push-button or external line) into a clean, single-clock-domain level.
- Output feeds the rising-edge pulse detector directly downstream, so that detector sees exactly one 0->1 transition per physical press.
- Structure: 2-FF synchronizer, then a 4-state debounce FSM with a stability counter.

---
 rtl/debounce_sync.sv | 86 ++++++++
 1 files changed

// File: rtl/debounce_sync.sv
// Two-flop synchronizer followed by a four-state debounce FSM. The output
// changes only after the synchronized input holds its new level for STABLE_CYCLES edges.
module debounce_sync #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic pending
);

  localparam int CNT_W = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOW,
    WAIT_HIGH,
    HIGH,
    WAIT_LOW
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= LOW;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter is loaded with 1 on entering a wait state because that
  // edge already counts as the first sample at the new level.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      LOW: begin
        if (sync2_q) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = LOW;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!sync2_q) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LOW: begin
        if (sync2_q) begin
          state_d = HIGH;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LOW;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LOW;
      end
    endcase
  end

  assign out     = (state_q == HIGH) || (state_q == WAIT_LOW);
  assign pending = (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);

endmodule
